// File: rtl/caesar_pkg.sv
// caesar_pkg
// Shared constants and types for the streaming Caesar/Vigenere cipher:
//   ALPHA     - alphabet size used for the modulo arithmetic
//   ASCII_UA  - code of 'A', base of the upper-case letter class
//   ASCII_LA  - code of 'a', base of the lower-case letter class
//   mode_e    - ENC adds the shift, DEC subtracts it
//   state_e   - message-tracking FSM states
//   reduce_shift() - folds a raw 5-bit shift into 0..25
package caesar_pkg;

    localparam int         ALPHA    = 26;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        MSG  = 1'b1
    } state_e;

    // A raw shift of 26..31 maps to 0..5, so stored shifts never exceed 25.
    function automatic logic [4:0] reduce_shift(input logic [4:0] s);
        return (s >= 5'(ALPHA)) ? s - 5'(ALPHA) : s;
    endfunction

endpackage

// File: rtl/caesar_stream_cipher_if.sv
// caesar_stream_cipher_if
// One character stream with a valid/ready handshake.
//   valid - character present (driven by master)
//   ready - receiver can accept (driven by slave)
//   data  - N-bit character (driven by master)
//   last  - final character of the message (driven by master)
interface caesar_stream_cipher_if #(
    parameter int N = 8
) ();

    logic         valid;
    logic         ready;
    logic [N-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);

endinterface

// File: rtl/caesar_shift_unit.sv
// caesar_shift_unit
// Combinational letter classifier and modulo-26 shifter.
//   ch        in  N  input character (classified on all N bits)
//   shift     in  5  shift amount, already reduced to 0..25
//   mode      in     ENC (+shift) or DEC (-shift)
//   res       out N  shifted letter, or ch unchanged for non-letters
//   is_letter out 1  ch is in 'A'..'Z' or 'a'..'z'
module caesar_shift_unit
    import caesar_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] ch,
    input  logic [4:0]   shift,
    input  mode_e        mode,
    output logic [N-1:0] res,
    output logic         is_letter
);

    localparam logic [N-1:0] UA = N'(ASCII_UA);
    localparam logic [N-1:0] ZU = UA + N'(ALPHA - 1);
    localparam logic [N-1:0] LA = N'(ASCII_LA);
    localparam logic [N-1:0] ZL = LA + N'(ALPHA - 1);

    logic         is_upper;
    logic         is_lower;
    logic [N-1:0] base;
    logic [4:0]   off;
    logic [5:0]   r;

    always_comb begin
        is_upper  = (ch >= UA) && (ch <= ZU);
        is_lower  = (ch >= LA) && (ch <= ZL);
        is_letter = is_upper || is_lower;
        base      = is_upper ? UA : LA;
        off       = 5'(ch - base);
        // r is a 6-bit two's-complement value: encrypt spans 0..50 (unsigned
        // compare), decrypt spans -25..25 so bit 5 is the sign.
        if (mode == ENC) begin
            r = {1'b0, off} + {1'b0, shift};
            if (r >= 6'(ALPHA)) begin
                r = r - 6'(ALPHA);
            end
        end else begin
            r = {1'b0, off} - {1'b0, shift};
            if (r[5]) begin
                r = r + 6'(ALPHA);
            end
        end
        res = is_letter ? base + N'(r[4:0]) : ch;
    end

endmodule

// File: rtl/caesar_stream_cipher.sv
// caesar_stream_cipher
// Streaming Caesar / Vigenere cipher, one character per cycle, one registered
// output stage.
//   clk        in        rising-edge clock
//   rst        in        synchronous active-high reset
//   key_we     in        write key_shift (reduced mod 26) into slot key_addr
//   key_addr   in  KW    key slot index
//   key_shift  in  5     raw shift amount
//   key_len    in  KW+1  active slot count, sampled on a message's first beat
//   mode       in  1     0 = encrypt, 1 = decrypt, sampled per beat
//   in_s       slave     input character stream
//   out_s      master    output character stream
//   busy       out 1     inside a multi-beat message
//
// state | meaning
// IDLE  | waiting for the first beat of a message
// MSG   | first beat accepted, last beat not yet seen (busy=1)
module caesar_stream_cipher
    import caesar_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int KEY_LEN = 4,
    localparam int KW      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_we,
    input  logic [KW-1:0]                 key_addr,
    input  logic [4:0]                    key_shift,
    input  logic [KW:0]                   key_len,
    input  logic                          mode,
    caesar_stream_cipher_if.slave         in_s,
    caesar_stream_cipher_if.master        out_s,
    output logic                          busy
);

    localparam logic [KW:0] MAX_LEN = (KW+1)'(KEY_LEN);

    logic [4:0]   key_mem [KEY_LEN];
    logic [KW-1:0] kidx;
    logic [KW:0]  len_q;
    logic [KW:0]  len_new;
    logic [KW:0]  len_cur;
    state_e       state;
    state_e       state_nxt;
    logic         first_beat;
    logic         accept;
    logic         is_letter;
    logic [N-1:0] res;

    // The output register may refill in the cycle it drains.
    assign in_s.ready = !out_s.valid || out_s.ready;
    assign accept     = in_s.valid && in_s.ready;

    always_comb begin
        len_new = key_len;
        if (key_len == '0 || key_len > MAX_LEN) begin
            len_new = (KW+1)'(1);
        end
        len_cur = first_beat ? len_new : len_q;
    end

    // Key RAM is read before this cycle's write lands, so a same-cycle
    // write only affects later beats.
    caesar_shift_unit #(.N(N)) u_shift (
        .ch        (in_s.data),
        .shift     (key_mem[kidx]),
        .mode      (mode_e'(mode)),
        .res       (res),
        .is_letter (is_letter)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        first_beat = 1'b0;
        case (state)
            IDLE: begin
                first_beat = 1'b1;
                if (accept && !in_s.last) begin
                    state_nxt = MSG;
                end
            end
            MSG: begin
                busy = 1'b1;
                if (accept && in_s.last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kidx  <= '0;
            len_q <= (KW+1)'(1);
        end else if (accept) begin
            if (first_beat) begin
                len_q <= len_new;
            end
            if (in_s.last) begin
                kidx <= '0;
            end else if (is_letter) begin
                kidx <= ({1'b0, kidx} == len_cur - 1'b1) ? '0 : kidx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_LEN; i++) begin
                key_mem[i] <= '0;
            end
        end else if (key_we && (int'(key_addr) < KEY_LEN)) begin
            key_mem[key_addr] <= reduce_shift(key_shift);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_s.valid <= 1'b0;
            out_s.data  <= '0;
            out_s.last  <= 1'b0;
        end else if (accept) begin
            out_s.valid <= 1'b1;
            out_s.data  <= res;
            out_s.last  <= in_s.last;
        end else if (out_s.ready) begin
            out_s.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_caesar_stream_cipher.sv
// tb_caesar_stream_cipher
// Directed-vector bench for caesar_stream_cipher. Expected strings are
// worked out by hand; a negedge monitor collects every output transfer.
module tb_caesar_stream_cipher;
    import caesar_pkg::*;

    localparam int N       = 8;
    localparam int KEY_LEN = 4;
    localparam int KW      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_we;
    logic [KW-1:0] key_addr;
    logic [4:0]    key_shift;
    logic [KW:0]   key_len;
    logic          mode;
    logic          busy;

    caesar_stream_cipher_if #(.N(N)) in_if ();
    caesar_stream_cipher_if #(.N(N)) out_if ();

    caesar_stream_cipher #(.N(N), .KEY_LEN(KEY_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_shift (key_shift),
        .key_len   (key_len),
        .mode      (mode),
        .in_s      (in_if),
        .out_s     (out_if),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_vec  = 0;
    int         n_miss = 0;
    int         cyc    = 0;
    logic [7:0] got_q [$];
    logic       last_q [$];
    logic       busy_q [$];
    int         stamp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_if.valid && out_if.ready) begin
            got_q.push_back(out_if.data);
            last_q.push_back(out_if.last);
            busy_q.push_back(busy);
            stamp_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        last_q.delete();
        busy_q.delete();
        stamp_q.delete();
    endtask

    // Callers enter and leave every task 1 time unit after a rising edge.
    task automatic key_write(input int addr, input int s);
        key_we    = 1'b1;
        key_addr  = KW'(addr);
        key_shift = 5'(s);
        @(posedge clk); #1;
        key_we    = 1'b0;
    endtask

    task automatic send_msg(input string s, input logic m);
        bit acc;
        int n;
        mode = m;
        for (int i = 0; i < s.len(); i++) begin
            in_if.valid = 1'b1;
            in_if.data  = s[i];
            in_if.last  = (i == s.len() - 1);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 100) begin
                @(negedge clk);
                acc = in_if.ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) chk("send_timeout", 32'd0, 32'd1);
        end
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic expect_msg(input string tag, input string exp);
        logic [7:0] g;
        logic       l;
        chk({tag, "_len"}, got_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            g = (i < got_q.size())  ? got_q[i]  : 8'hff;
            l = (i < last_q.size()) ? last_q[i] : 1'bx;
            chk($sformatf("%s_c%0d", tag, i), g, exp[i]);
            chk($sformatf("%s_last%0d", tag, i), l, (i == exp.len() - 1));
        end
    endtask

    task automatic run(input string tag, input string msg, input logic m, input string exp);
        clear_q();
        send_msg(msg, m);
        drain();
        expect_msg(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        key_we       = 1'b0;
        key_addr     = '0;
        key_shift    = '0;
        key_len      = 3'd1;
        mode         = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_data",  out_if.data,  0);
        chk("rst_out_last",  out_if.last,  0);
        chk("rst_busy",      busy,         0);
        chk("rst_in_ready",  in_if.ready,  1);
        @(posedge clk); #1;

        // Single-key Caesar, full throughput.
        key_write(0, 3);
        run("hello", "HELLO", ENC, "KHOOR");
        if (stamp_q.size() == 5) chk("hello_b2b", stamp_q[4] - stamp_q[0], 4);
        else                     chk("hello_b2b", stamp_q.size(), 5);
        chk("hello_busy_mid", (busy_q.size() > 0) ? busy_q[0] : 1'b0, 1);
        chk("hello_busy_end", (busy_q.size() > 4) ? busy_q[4] : 1'b1, 0);
        chk("hello_busy_after", busy, 0);

        // Alphabet wrap, case preservation, non-letters.
        key_write(0, 2);
        run("wrap_enc", "zY", ENC, "bA");
        key_write(0, 1);
        run("wrap_dec", "aA5", DEC, "zZ5");
        key_write(0, 0);
        run("ident", "Qm", ENC, "Qm");
        key_write(0, 25);
        run("max_enc", "b", ENC, "a");
        run("max_dec", "a", DEC, "b");
        run("edges", "@[`{", ENC, "@[`{");

        // Repeating multi-slot key.
        key_write(0, 1);
        key_write(1, 2);
        key_write(2, 3);
        key_len = 3'd3;
        run("vig", "abc d", ENC, "bdf e");
        run("vig_restart", "aaaa", ENC, "bcdb");
        run("vig_dec", "bdf e", DEC, "abc d");
        key_len = 3'd0;
        run("len0", "aaa", ENC, "bbb");
        key_len = 3'd5;
        run("len_over", "bb", ENC, "cc");

        // Stored shift is reduced modulo 26.
        key_len = 3'd1;
        key_write(0, 29);
        run("red29", "a", ENC, "d");
        key_write(0, 31);
        run("red31", "a", ENC, "f");

        // Key write mid-message: the beat accepted in the write cycle still
        // uses the old shift.
        key_write(0, 1);
        clear_q();
        fork
            send_msg("aaaa", ENC);
            begin
                @(posedge clk); #1;
                key_we    = 1'b1;
                key_addr  = '0;
                key_shift = 5'd5;
                @(posedge clk); #1;
                key_we    = 1'b0;
            end
        join
        drain();
        expect_msg("kw_mid", "bbff");

        // Backpressure: out_ready low for three cycles while 'c' is held.
        key_write(0, 1);
        clear_q();
        fork
            send_msg("abcdef", ENC);
            begin
                repeat (2) @(posedge clk);
                #1 out_if.ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk($sformatf("bp_data%0d", k),     out_if.data,  8'h63);
                    chk($sformatf("bp_valid%0d", k),    out_if.valid, 1);
                    chk($sformatf("bp_in_ready%0d", k), in_if.ready,  0);
                end
                @(posedge clk);
                #1 out_if.ready = 1'b1;
            end
        join
        drain();
        expect_msg("bp", "bcdefg");

        // Reset in the middle of a message.
        key_write(0, 3);
        clear_q();
        mode        = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = 8'h61;
        in_if.last  = 1'b0;
        @(posedge clk); #1;
        in_if.valid = 1'b0;
        chk("rm_busy_pre", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rm_out_valid", out_if.valid, 0);
        chk("rm_busy", busy, 0);
        rst = 1'b0;
        clear_q();
        run("post_rst", "Hi!z", ENC, "Hi!z");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/caesar_stream_cipher.md
# caesar_stream_cipher

Streaming, parametrised successor to the team's combinational Caesar adder. Accepts one ASCII character per cycle over a valid/ready handshake and applies a modulo-26 letter shift. The shift is either a single Caesar key or a repeating multi-slot (Vigenère-style) key, in encrypt or decrypt mode. Sits between the byte source (UART/host FIFO) and the byte sink in the cryptography datapath, with one registered output stage.

## Interface
- `N`, 8: character width in bits. Classification uses the full N-bit value; N ≥ 8.
- `KEY_LEN`, 4: number of key slots; `KW = $clog2(KEY_LEN)` (minimum 1).
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `key_we`  in  1  write `key_shift` into slot `key_addr`.
- `key_addr`  in  KW  key slot index.
- `key_shift`  in  5  shift amount; stored reduced mod 26 (29 → 3).
- `key_len`  in  KW+1  active slot count; sampled on the first beat of each message; 0 or >KEY_LEN is treated as 1.
- `mode`  in  1  0 = encrypt (+shift), 1 = decrypt (−shift); sampled per beat.
- `in_valid`  in  1  input character valid.
- `in_ready`  out  1  block can accept.
- `in_data`  in  N  plaintext/ciphertext character.
- `in_last`  in  1  final character of message.
- `out_valid`  out  1  output character valid.
- `out_ready`  in  1  sink can accept.
- `out_data`  out  N  transformed character.
- `out_last`  out  1  copy of `in_last` for this beat.
- `busy`  out  1  mid-message (first beat accepted, last not yet).

## Operation
- Transfer occurs when valid && ready, on both sides.
- Letter classes: upper `'A'..'Z'` (base 0x41) and lower `'a'..'z'` (base 0x61). The offset o = c − base is in 0..25.
- Encrypt: r = o + s; if r ≥ 26 then r −= 26.
- Decrypt: r = o − s; if r < 0 then r += 26.
- Use a 6-bit signed intermediate. Output is base + r, so case is preserved.
- Non-letters pass through unchanged and do not advance the key index.
- The key index `kidx` starts at 0 and advances by 1 on each accepted letter. After slot `len−1` it wraps to 0.
- Accepting a beat with `in_last=1` forces `kidx` to 0 and latches a new length on the next message's first beat.
- `s = key[kidx]`. A key write in the same cycle as an accepted beat does not affect that beat. It takes effect from the next cycle, including mid-message.
- State: `IDLE` (awaiting first beat) and `MSG` (`busy=1`).
  - `IDLE` → `MSG` on an accepted beat with `in_last=0`.
  - `MSG` → `IDLE` on an accepted beat with `in_last=1`.
  - A single-beat message stays in `IDLE`.

## Timing
- Latency: one cycle from input acceptance to `out_valid`.
- `in_ready = !out_valid || out_ready`. The output register is refilled in the same cycle it drains, so throughput is 1 character/cycle with `out_ready` held high.
- While `out_valid && !out_ready`, `out_data` and `out_last` are held stable and no input is accepted.
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `busy=0`.
  - `kidx=0`, all key slots 0, state `IDLE`.
  - `in_ready=1` from the first cycle after reset.
- Reset mid-message discards the in-flight output and clears the key slots. The next accepted beat is treated as a first beat.
- Wrap boundaries:
  - `'z'` + 1 → `'a'`.
  - `'A'` − 1 → `'Z'`.
  - A shift of 0 is identity.
  - A stored shift of 25 is the maximum.

## Structure
- Package `caesar_pkg`: `ALPHA=26`, `ASCII_UA=8'h41`, `ASCII_LA=8'h61`, and the mode enum `{ENC, DEC}`.
- Sub-module `caesar_shift_unit` (combinational) handles character classification and the mod-26 add/subtract. It is instantiated once.
- The top level holds the key RAM (register array), `kidx` and the length register, the FSM, and the output register.

## Test plan
- Encrypt `"HELLO"` with key_len 1, slot0=3, `out_ready` held at 1 → `"KHOOR"` on consecutive cycles, `out_last` on `'R'`. Then `busy` deasserts.
- Wrap and case: encrypt `'z'`,`'Y'` with s=2 → `'b'`,`'A'`. Decrypt `'a'` with s=1 → `'z'`. Input `'5'` → `'5'`.
- Vigenère: key_len 3, slots [1,2,3], encrypt `"abc d"` → `"bdf e"`. The space does not advance the index. The next message restarts at slot 0.
- Backpressure: drop `out_ready` for 3 cycles mid-stream. `out_data` is held and `in_ready=0`. No beat is lost or duplicated.
- Key write `key_shift=29` to slot 0 → stored 3. A write to slot 0 issued mid-message applies from the next character only.
- Reset asserted while `busy=1` → next cycle `out_valid=0` and `busy=0`. The following message with all-zero keys passes through unchanged.
